axi4_burst_read_to_wishbone: RTL

Read-only AXI4 slave to classic Wishbone master bridge for processor instruction and read ports, supporting FIXED, INCR and WRAP bursts of up to 256 beats. WB reads are prefetched into a FIFO_DEPTH-entry response FIFO so WB traffic continues while the master stalls RREADY. Sits between the core's AXI4 fetch port and the WB memory/interconnect.

---
 rtl/axi4_burst_read_to_wishbone_pkg.sv | 21 ++
 rtl/axi4_burst_read_to_wishbone_if.sv | 40 ++++
 rtl/axi4_burst_read_to_wishbone_sync_fifo.sv | 48 ++++
 rtl/axi4_burst_read_to_wishbone.sv | 128 ++++++++++++
 4 files changed

// File: rtl/axi4_burst_read_to_wishbone_pkg.sv
// Shared types and constants for the AXI4 read to Wishbone bridge.
package axi_wb_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_ERR_FILL,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/axi4_burst_read_to_wishbone_if.sv
// AXI4 read channels plus classic Wishbone master signals seen by the bridge.
interface axi4_burst_read_to_wishbone_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   AXI_ARID;
    logic [ADDR_WIDTH-1:0] AXI_ARADDR;
    logic [7:0]            AXI_ARLEN;
    logic [1:0]            AXI_ARBURST;
    logic                  AXI_ARVALID;
    logic                  AXI_ARREADY;
    logic [ID_WIDTH-1:0]   AXI_RID;
    logic [DATA_WIDTH-1:0] AXI_RDATA;
    logic [1:0]            AXI_RRESP;
    logic                  AXI_RLAST;
    logic                  AXI_RVALID;
    logic                  AXI_RREADY;
    logic                  WB_CYC;
    logic                  WB_STB;
    logic [ADDR_WIDTH-1:0] WB_ADDR;
    logic [DATA_WIDTH-1:0] WB_RDATA;
    logic                  WB_ACK;
    logic                  WB_ERR;

    // The bridge: AXI slave on one side, Wishbone master on the other.
    modport slave (
        input  AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARBURST, AXI_ARVALID, AXI_RREADY,
               WB_RDATA, WB_ACK, WB_ERR,
        output AXI_ARREADY, AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID,
               WB_CYC, WB_STB, WB_ADDR
    );

    modport master (
        output AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARBURST, AXI_ARVALID, AXI_RREADY,
               WB_RDATA, WB_ACK, WB_ERR,
        input  AXI_ARREADY, AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID,
               WB_CYC, WB_STB, WB_ADDR
    );
endinterface

// File: rtl/axi4_burst_read_to_wishbone_sync_fifo.sv
// Single-clock FIFO holding response beats between Wishbone and the AXI R channel.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end
endmodule

// File: rtl/axi4_burst_read_to_wishbone.sv
// Read-only AXI4 slave to classic Wishbone master; WB reads prefetch into a response FIFO.
//  state       | meaning
//  ST_IDLE     | ARREADY high, waiting for a read address
//  ST_BURST    | WB cycle open, one beat pushed per sampled ACK/ERR
//  ST_ERR_FILL | no WB access, pushing SLVERR beats for the remaining count
//  ST_DRAIN    | every beat queued, waiting for the RLAST beat to pop
module axi4_burst_read_to_wishbone
    import axi_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    axi4_burst_read_to_wishbone_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int FW    = DATA_WIDTH + 3;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    state_t                state;
    burst_t                burst_q;
    logic                  arready_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_inc, addr_next, wrap_mask;
    logic [7:0]            len_q;
    logic [8:0]            beats_left;
    logic                  ar_hs, ar_legal, last_beat;
    logic                  wb_stb, wb_ack_beat, wb_err_beat, push, pop;
    logic [FW-1:0]         push_word, head_word;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;

    assign ar_hs = bus.AXI_ARVALID & arready_q;

    always_comb begin
        ar_legal = 1'b1;
        if (bus.AXI_ARBURST == BURST_RSVD)
            ar_legal = 1'b0;
        else if (bus.AXI_ARBURST == BURST_WRAP)
            ar_legal = (bus.AXI_ARLEN == 8'd1) || (bus.AXI_ARLEN == 8'd3) ||
                       (bus.AXI_ARLEN == 8'd7) || (bus.AXI_ARLEN == 8'd15);
    end

    // WRAP window is (len+1)*BYTES, a power of two for every accepted burst.
    assign wrap_mask = ADDR_WIDTH'((int'(len_q) + 1) * BYTES - 1);
    assign addr_inc  = addr_q + ADDR_WIDTH'(BYTES);

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            BURST_INCR: addr_next = addr_inc;
            BURST_WRAP: addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default:    addr_next = addr_q;
        endcase
    end

    assign last_beat   = (beats_left == 9'd1);
    assign wb_stb      = (state == ST_BURST) && (fifo_count < CW'(FIFO_DEPTH));
    assign wb_err_beat = wb_stb & bus.WB_ERR;
    assign wb_ack_beat = wb_stb & bus.WB_ACK & ~bus.WB_ERR;
    assign push        = wb_ack_beat | wb_err_beat | ((state == ST_ERR_FILL) & ~fifo_full);
    assign push_word   = wb_ack_beat ? {bus.WB_RDATA, RESP_OKAY, last_beat}
                                     : {{DATA_WIDTH{1'b0}}, RESP_SLVERR, last_beat};
    assign pop         = ~fifo_empty & bus.AXI_RREADY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            arready_q  <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            burst_q    <= BURST_FIXED;
            beats_left <= '0;
        end else begin
            case (state)
                ST_IDLE: if (ar_hs) begin
                    id_q       <= bus.AXI_ARID;
                    addr_q     <= bus.AXI_ARADDR & ~ADDR_WIDTH'(BYTES - 1);
                    len_q      <= bus.AXI_ARLEN;
                    burst_q    <= burst_t'(bus.AXI_ARBURST);
                    beats_left <= {1'b0, bus.AXI_ARLEN} + 9'd1;
                    arready_q  <= 1'b0;
                    state      <= ar_legal ? ST_BURST : ST_ERR_FILL;
                end
                ST_BURST: if (push) begin
                    beats_left <= beats_left - 9'd1;
                    if (wb_ack_beat) addr_q <= addr_next;
                    if (last_beat)        state <= ST_DRAIN;
                    else if (wb_err_beat) state <= ST_ERR_FILL;
                end
                ST_ERR_FILL: if (push) begin
                    beats_left <= beats_left - 9'd1;
                    if (last_beat) state <= ST_DRAIN;
                end
                ST_DRAIN: if (pop && head_word[0]) begin
                    state     <= ST_IDLE;
                    arready_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_word),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Gate ARREADY with reset so it is 0 in reset yet 1 on the first cycle after release.
    assign bus.AXI_ARREADY = arready_q & rst_n;
    assign bus.AXI_RID     = id_q;
    assign bus.AXI_RVALID  = ~fifo_empty;
    assign {bus.AXI_RDATA, bus.AXI_RRESP, bus.AXI_RLAST} = fifo_empty ? '0 : head_word;
    assign bus.WB_CYC      = (state == ST_BURST);
    assign bus.WB_STB      = wb_stb;
    assign bus.WB_ADDR     = addr_q;
endmodule
